// File: rtl/window_3x3.sv
// window_3x3: forms 3x3 pixel windows from column triples supplied by a line buffer,
// dropping windows that would overlap the left/top image border.
module window_3x3 #(
    parameter int WIDTH_P = 8,
    parameter int IMG_W_P = 16,
    parameter int IMG_H_P = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [WIDTH_P-1:0]   data_i,
    input  logic [WIDTH_P-1:0]   line1_i,
    input  logic [WIDTH_P-1:0]   line2_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [9*WIDTH_P-1:0] window_o,
    output logic                 last_o
);
    localparam int CW = ($clog2(IMG_W_P) < 1) ? 1 : $clog2(IMG_W_P);
    localparam int RW = ($clog2(IMG_H_P) < 1) ? 1 : $clog2(IMG_H_P);

    if (IMG_W_P < 3 || IMG_H_P < 3) begin : g_bad_size
        $fatal(1, "window_3x3: image must be at least 3x3");
    end

    logic [3*WIDTH_P-1:0] c0, c1, c2, ncol;
    logic [CW-1:0]        col;
    logic [RW-1:0]        row;
    logic [9*WIDTH_P-1:0] win;
    logic                 hs, produce, col_end, row_end;

    assign ready_o = !valid_o | ready_i;
    assign hs      = valid_i & ready_o;
    assign col_end = col == CW'(IMG_W_P - 1);
    assign row_end = row == RW'(IMG_H_P - 1);
    assign produce = hs && col >= CW'(2) && row >= RW'(2);
    assign ncol    = {line2_i, line1_i, data_i};

    // column words pack the top row (line2) in the high slice, so row r lives at slice 2-r
    for (genvar r = 0; r < 3; r++) begin : g_row
        assign win[(3*r)*WIDTH_P   +: WIDTH_P] = c1[(2-r)*WIDTH_P +: WIDTH_P];
        assign win[(3*r+1)*WIDTH_P +: WIDTH_P] = c2[(2-r)*WIDTH_P +: WIDTH_P];
        assign win[(3*r+2)*WIDTH_P +: WIDTH_P] = ncol[(2-r)*WIDTH_P +: WIDTH_P];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            c0       <= '0;
            c1       <= '0;
            c2       <= '0;
            col      <= '0;
            row      <= '0;
            valid_o  <= 1'b0;
            last_o   <= 1'b0;
            window_o <= '0;
        end else begin
            if (hs) begin
                c0  <= c1;
                c1  <= c2;
                c2  <= ncol;
                col <= col_end ? '0 : col + 1'b1;
                if (col_end)
                    row <= row_end ? '0 : row + 1'b1;
            end
            if (produce) begin
                window_o <= win;
                last_o   <= col_end & row_end;
                valid_o  <= 1'b1;
            end else if (ready_i) begin
                valid_o  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_window_3x3.sv
// tb_window_3x3: table-driven and scoreboard checks of window_3x3 on a 4x4 image.
module tb_window_3x3;
    localparam int W  = 8;
    localparam int IW = 4;
    localparam int IH = 4;
    localparam logic [71:0] FIRST = 72'h0a_09_08_06_05_04_02_01_00;

    logic clk = 1'b0;
    logic rst, valid_i, ready_o, valid_o, ready_i, last_o;
    logic [W-1:0] data_i, line1_i, line2_i;
    logic [9*W-1:0] window_o;
    logic rdy_force = 1'b1, rand_mode = 1'b0, rnd_bit = 1'b1;

    assign ready_i = rand_mode ? rnd_bit : rdy_force;

    window_3x3 #(.WIDTH_P(W), .IMG_W_P(IW), .IMG_H_P(IH)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
        .data_i(data_i), .line1_i(line1_i), .line2_i(line2_i),
        .valid_o(valid_o), .ready_i(ready_i), .window_o(window_o), .last_o(last_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [71:0] win; logic last; } exp_t;
    typedef struct { logic produce; logic last; } vec_t;
    exp_t q[$];
    vec_t tbl[16];
    int checks = 0, errors = 0, wins = 0, mx = 0, my = 0;
    logic [15:0] last_mask = '0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] v(input int base, input int idx);
        return idx < 0 ? 8'd0 : 8'(base + idx);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && valid_o && ready_i) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_window: got %h expected none", window_o);
            end else begin
                e = q.pop_front();
                chk("sb_window", window_o, e.win);
                chk("sb_last", 72'(last_o), 72'(e.last));
            end
            if (last_o && wins < 16) last_mask[wins] = 1'b1;
            wins++;
        end
    end

    initial forever begin
        @(posedge clk);
        #1 rnd_bit = 1'($urandom_range(0, 1));
    end

    task automatic send(input int base, input int p, input bit gaps);
        int t;
        logic [71:0] w;
        if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        data_i  = v(base, p);
        line1_i = v(base, p - IW);
        line2_i = v(base, p - 2*IW);
        valid_i = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!ready_o && t < 50);
        if (!ready_o) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout p=%0d: got ready_o=0 expected 1", p);
        end else begin
            if (mx >= 2 && my >= 2) begin
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        w[(3*r+c)*8 +: 8] = v(base, p - (2-r)*IW - (2-c));
                q.push_back('{w, (mx == IW-1 && my == IH-1)});
            end
            if (mx == IW-1) begin
                mx = 0;
                my = (my == IH-1) ? 0 : my + 1;
            end else mx++;
        end
        @(posedge clk);
        #1 valid_i = 1'b0;
    endtask

    task automatic run_frame();
        for (int p = 0; p < 16; p++) begin
            send(0, p, 1'b0);
            chk($sformatf("valid_p%0d", p), 72'(valid_o), 72'(tbl[p].produce));
            chk($sformatf("last_p%0d", p), 72'(valid_o & last_o), 72'(tbl[p].last));
            if (p == 10) chk("first_window", window_o, FIRST);
        end
    endtask

    task automatic drain(input string name, input int exp_wins);
        int t = 0;
        while (q.size() != 0 && t < 50) begin @(negedge clk); t++; end
        @(posedge clk);
        #1 chk(name, 72'(wins), 72'(exp_wins));
    endtask

    initial begin
        logic [71:0] saved;
        for (int i = 0; i < 16; i++) tbl[i] = '{1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b0};
        tbl[14] = '{1'b1, 1'b0};
        tbl[15] = '{1'b1, 1'b1};

        rst = 1'b1; valid_i = 1'b0; data_i = '0; line1_i = '0; line2_i = '0;
        #12;
        chk("rst_valid", 72'(valid_o), 72'(0));
        chk("rst_last", 72'(last_o), 72'(0));
        chk("rst_window", window_o, 72'(0));
        chk("rst_ready", 72'(ready_o), 72'(1));
        @(posedge clk);
        #1 rst = 1'b0;
        chk("post_rst_ready", 72'(ready_o), 72'(1));

        wins = 0;
        run_frame();
        drain("frame1_windows", 4);

        wins = 0;
        for (int p = 0; p <= 10; p++) send(0, p, 1'b0);
        rdy_force = 1'b0;
        saved = window_o;
        chk("hold_start_valid", 72'(valid_o), 72'(1));
        data_i = v(0, 11); line1_i = v(0, 7); line2_i = v(0, 3); valid_i = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("hold_valid", 72'(valid_o), 72'(1));
            chk("hold_window", window_o, saved);
            chk("hold_ready", 72'(ready_o), 72'(0));
        end
        valid_i = 1'b0;
        @(posedge clk);
        #1 rdy_force = 1'b1;
        for (int p = 11; p < 16; p++) send(0, p, 1'b0);
        drain("hold_windows", 4);

        wins = 0;
        for (int p = 0; p <= 11; p++) send(0, p, 1'b0);
        rdy_force = 1'b0;
        chk("pending_before_rst", 72'(valid_o), 72'(1));
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 72'(valid_o), 72'(0));
        chk("async_rst_window", window_o, 72'(0));
        chk("async_rst_ready", 72'(ready_o), 72'(1));
        q.delete();
        mx = 0; my = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        rdy_force = 1'b1;
        wins = 0;
        run_frame();
        drain("restart_windows", 4);

        wins = 0;
        last_mask = '0;
        rand_mode = 1'b1;
        for (int f = 0; f < 2; f++)
            for (int p = 0; p < 16; p++) send(50 * (f + 1), p, 1'b1);
        rand_mode = 1'b0;
        drain("two_frame_windows", 8);
        chk("two_frame_last_pos", 72'(last_mask), 72'(16'h0088));
        chk("queue_empty", 72'(q.size()), 72'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/window_3x3.md
WINDOW_3X3 -- requirements
Module: window_3x3

Interface
REQ-001 The block SHALL have parameter WIDTH_P, default 8, giving the pixel width in bits.
REQ-002 The block SHALL have parameter IMG_W_P, default 16, giving the image width in pixels.
REQ-003 The block SHALL have parameter IMG_H_P, default 12, giving the image height in rows.
REQ-004 Port clk_i SHALL be an input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 Port rst_i SHALL be an input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port valid_i SHALL be an input, 1 bit: the upstream column (data_i, line1_i, line2_i) is valid.
REQ-007 Port ready_o SHALL be an output, 1 bit: the block accepts the upstream column this cycle.
REQ-008 Port data_i SHALL be an input, WIDTH_P bits: the current pixel (bottom row of the window).
REQ-009 Port line1_i SHALL be an input, WIDTH_P bits: the pixel one line earlier (middle row), as delivered by the line-delay buffer.
REQ-010 Port line2_i SHALL be an input, WIDTH_P bits: the pixel two lines earlier (top row).
REQ-011 Port valid_o SHALL be an output, 1 bit: window_o and last_o hold a complete window.
REQ-012 Port ready_i SHALL be an input, 1 bit: the downstream stage accepts the window.
REQ-013 Port window_o SHALL be an output, 9*WIDTH_P bits: the 3x3 window; element k = 3*r + c occupies bits [(k+1)*WIDTH_P-1 : k*WIDTH_P], with r=0 the top row (line2), r=2 the bottom row (data_i), c=0 the oldest (leftmost) column and c=2 the newest column.
REQ-014 Port last_o SHALL be an output, 1 bit: marks the final window of a frame.

Function
REQ-015 A handshake SHALL occur when valid_i & ready_o are both high; only a handshake advances any state.
REQ-016 On each handshake, the three column registers SHALL shift: c0<-c1, c1<-c2, c2<-{line2_i, line1_i, data_i}.
REQ-017 The column counter SHALL run 0..IMG_W_P-1 and increment on each handshake, wrapping to 0 after IMG_W_P-1.
REQ-018 The row counter SHALL increment when the column counter wraps, and SHALL wrap to 0 after IMG_H_P-1 (end of frame).
REQ-019 A handshake with column >= 2 and row >= 2 (counter values before the increment) SHALL load the output register on the next edge: window_o = the shifted window, valid_o=1.
REQ-020 Handshakes with column < 2 or row < 2 SHALL be consumed silently, with no output; windows SHALL never span a line wrap.
REQ-021 last_o SHALL be loaded as 1 exactly when the producing handshake is at column IMG_W_P-1 and row IMG_H_P-1; otherwise it SHALL be loaded as 0.
REQ-022 Latency from the producing handshake to valid_o=1 SHALL be 1 cycle.
REQ-023 ready_o SHALL equal !valid_o | ready_i, so the block sustains one window per cycle under continuous flow.
REQ-024 While valid_o=1 and ready_i=0, window_o, last_o and valid_o SHALL hold stable and ready_o SHALL be 0.
REQ-025 Output accept and a non-producing input handshake in the same cycle SHALL clear valid_o.
REQ-026 Output accept and a producing input handshake in the same cycle SHALL reload the output register, with valid_o remaining 1.
REQ-027 Each frame SHALL produce exactly (IMG_W_P-2)*(IMG_H_P-2) windows.
REQ-028 Elaboration SHALL fail via $fatal if IMG_W_P < 3 or IMG_H_P < 3.
REQ-029 Counter widths SHALL be $clog2(IMG_W_P) for the column counter and $clog2(IMG_H_P) for the row counter, each with a minimum of 1 bit.

Reset
REQ-030 While rst_i=1, valid_o, last_o, window_o, all column registers, and both counters SHALL be 0.
REQ-031 Consequently ready_o SHALL be 1 during and immediately after reset.
REQ-032 Reset asserted mid-frame SHALL discard any pending window; the next handshake after reset SHALL be treated as row 0, column 0.

Verification
REQ-033 W=4, H=4, WIDTH=8; stream pixel p=0..15 with data_i=p, line1_i=p-4, line2_i=p-8 (0 when negative), ready_i=1 -> the first valid_o comes 1 cycle after p=10 with window {0,1,2,4,5,6,8,9,10} for k=0..8.
REQ-034 Same stream -> exactly 4 windows: centres 5, 6, 9, 10, with last_o=1 only on the window {5,6,7,9,10,11,13,14,15}.
REQ-035 Hold ready_i=0 for 5 cycles while the first window is pending -> valid_o stays 1, window_o is unchanged, ready_o=0, no input is consumed, and the counters are frozen.
REQ-036 Handshakes at p=12 and p=13 (row 3, columns 0 and 1) -> no valid_o and no last_o.
REQ-037 Assert rst_i asynchronously after p=11 with a window pending -> valid_o=0 immediately; restarting the stream at p=0 reproduces REQ-033 exactly.
REQ-038 Stream two back-to-back frames with random valid_i/ready_i gaps -> 8 windows total, last_o on windows 4 and 8, and contents matching a reference model.
